// File: rtl/famicom_input_serializer.sv
// Famicom controller emulation for the Gigatron: merges live pad buttons with queued
// ASCII keystrokes and shifts the result out serially, active-low, on the latch/pulse protocol.
module famicom_input_serializer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_FRAMES = 2,
  parameter int GAP_FRAMES  = 1
) (
  input  logic       clk_app,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_ascii,
  input  logic [7:0] joy_bits,
  input  logic       famicom_latch,
  input  logic       famicom_pulse,
  output logic       famicom_data,
  output logic       fifo_full,
  output logic       key_dropped,
  output logic       busy
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int CNT_MAX = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
  localparam int NW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [NW-1:0] cnt;
  logic [7:0]    cur_key;
  logic [7:0]    shift;
  logic          latch_d, pulse_d, dropped;

  logic          frame_evt, pulse_rise, full, empty, pop, key_ok, push, drop;
  logic [7:0]    presented, load_word;

  assign frame_evt  = latch_d & ~famicom_latch;
  assign pulse_rise = famicom_pulse & ~pulse_d;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // Popping only while latch is low keeps every latch window on a single byte.
  assign pop        = (state == ST_IDLE) && !empty && !famicom_latch;
  assign key_ok     = key_valid && (key_ascii != 8'hFF);
  assign push       = key_ok && (!full || pop);
  assign drop       = key_ok && full && !pop;
  assign presented  = (state == ST_HOLD) ? cur_key : 8'hFF;

  // Bit-reversed so the key leaves MSB first; a pressed button pulls its bit low.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_load
      assign load_word[gi] = ~joy_bits[gi] & presented[7-gi];
    end
  endgenerate

  always_ff @(posedge clk_app) begin
    if (push) mem[wr_ptr] <= key_ascii;
  end

  always_ff @(posedge clk_app or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= drop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_app or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cur_key <= 8'hFF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_key <= mem[rd_ptr];
            cnt     <= NW'(HOLD_FRAMES);
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (frame_evt) begin
            if (cnt == NW'(1)) begin
              if (GAP_FRAMES > 0) begin
                state <= ST_GAP;
                cnt   <= NW'(GAP_FRAMES);
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              cnt <= cnt - NW'(1);
            end
          end
        end
        ST_GAP: begin
          if (frame_evt) begin
            if (cnt == NW'(1)) state <= ST_IDLE;
            else               cnt   <= cnt - NW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Latch is level-sensitive and overrides the shift clock.
  always_ff @(posedge clk_app or posedge reset) begin
    if (reset) begin
      shift   <= 8'hFF;
      latch_d <= 1'b0;
      pulse_d <= 1'b0;
    end else begin
      latch_d <= famicom_latch;
      pulse_d <= famicom_pulse;
      if (famicom_latch)   shift <= load_word;
      else if (pulse_rise) shift <= {1'b1, shift[7:1]};
    end
  end

  assign famicom_data = shift[0];
  assign fifo_full    = full;
  assign key_dropped  = dropped;
  assign busy         = (state != ST_IDLE) || !empty;

endmodule
